// File: rtl/lb_echo_pkg.sv
// Shared types and constants for the local-bus echo master.
// Register map, FSM state encoding and the ASCII case-fold helper.
package lb_echo_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_POLL,
      S_PWAIT,
      S_DECIDE,
      S_RX_RD,
      S_RWAIT,
      S_TX_WR
   } state_e;

   localparam logic ADR_DATA   = 1'b0;
   localparam logic ADR_STATUS = 1'b1;

   localparam int ST_RX_READY = 0;
   localparam int ST_TX_READY = 1;

   localparam logic [7:0] CHAR_LC_A = 8'h61;
   localparam logic [7:0] CHAR_LC_Z = 8'h7A;
   localparam logic [7:0] CASE_BIT  = 8'h20;

   function automatic logic [7:0] fold_case(input logic [7:0] b);
      return ((b >= CHAR_LC_A) && (b <= CHAR_LC_Z)) ? (b & ~CASE_BIT) : b;
   endfunction

endpackage

// File: rtl/lb_byte_fifo.sv
// 8-bit synchronous FIFO; one extra pointer bit distinguishes full from empty.
module lb_byte_fifo #(
   parameter int DEPTH = 4
) (
   input  logic       clk,
   input  logic       reset_ns,
   input  logic       push_i,
   input  logic [7:0] wdata_i,
   input  logic       pop_i,
   output logic [7:0] rdata_o,
   output logic       empty_o,
   output logic       full_o
);
   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;

   logic [7:0]    mem_q [DEPTH];
   logic [PW-1:0] wr_ptr_q, rd_ptr_q;

   assign empty_o = (wr_ptr_q == rd_ptr_q);
   assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

   always_ff @(posedge clk or negedge reset_ns) begin
      if (!reset_ns) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         if (push_i && !full_o)  wr_ptr_q <= wr_ptr_q + PW'(1);
         if (pop_i  && !empty_o) rd_ptr_q <= rd_ptr_q + PW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (push_i && !full_o) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
   end

endmodule

// File: rtl/lb_echo_master.sv
// Firmware-free UART echo: polls status, buffers RX bytes, writes them back to TX.
// Every bus output comes straight from a register; strobes are single-cycle.
module lb_echo_master
   import lb_echo_pkg::*;
#(
   parameter int FIFO_DEPTH = 4,
   parameter int READ_WAIT  = 1,
   parameter int CASE_FOLD  = 0
) (
   input  logic        clk,
   input  logic        reset_ns,
   input  logic        enable,
   input  logic [7:0]  data_out,
   output logic [7:0]  data_in,
   output logic        adrs,
   output logic        CSn,
   output logic        WE,
   output logic        OE,
   output logic        busy,
   output logic        fifo_full,
   output logic [15:0] byte_count
);
   localparam logic [2:0] WAIT_INIT = 3'(READ_WAIT - 1);

   state_e      state_q;
   logic [2:0]  wait_q;
   logic [1:0]  status_q;
   logic        csn_q, we_q, oe_q, adrs_q, busy_q, gap_q;
   logic [7:0]  data_q;
   logic [15:0] cnt_q;

   logic       fifo_empty, fifo_full_w, fifo_push, fifo_pop;
   logic [7:0] fifo_rdata, rx_byte;
   logic       go_tx, go_rx, txn_done, start_poll;

   assign go_tx = status_q[ST_TX_READY] && !fifo_empty;
   assign go_rx = status_q[ST_RX_READY] && !fifo_full_w;

   assign fifo_push = (state_q == S_RWAIT) && (wait_q == 3'd0);
   assign fifo_pop  = (state_q == S_TX_WR) && !gap_q;
   assign rx_byte   = (CASE_FOLD != 0) ? fold_case(data_out) : data_out;

   // TX_WR holds one quiet cycle after its strobe so the next POLL strobe is never adjacent.
   assign txn_done   = fifo_push || ((state_q == S_TX_WR) && gap_q) ||
                       ((state_q == S_DECIDE) && !go_tx && !go_rx);
   assign start_poll = enable && ((state_q == S_IDLE) || txn_done);

   lb_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk      (clk),
      .reset_ns (reset_ns),
      .push_i   (fifo_push),
      .wdata_i  (rx_byte),
      .pop_i    (fifo_pop),
      .rdata_o  (fifo_rdata),
      .empty_o  (fifo_empty),
      .full_o   (fifo_full_w)
   );

   always_ff @(posedge clk or negedge reset_ns) begin
      if (!reset_ns) begin
         state_q  <= S_IDLE;
         wait_q   <= '0;
         status_q <= '0;
         csn_q    <= 1'b1;
         we_q     <= 1'b0;
         oe_q     <= 1'b0;
         adrs_q   <= ADR_DATA;
         data_q   <= '0;
         cnt_q    <= '0;
         gap_q    <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         csn_q <= 1'b1;
         we_q  <= 1'b0;
         oe_q  <= 1'b0;
         case (state_q)
            S_POLL: begin
               state_q <= S_PWAIT;
               wait_q  <= WAIT_INIT;
            end
            S_PWAIT: begin
               if (wait_q == 3'd0) begin
                  status_q <= data_out[1:0];
                  state_q  <= S_DECIDE;
               end else begin
                  wait_q <= wait_q - 3'd1;
               end
            end
            S_DECIDE: begin
               if (go_tx) begin
                  state_q <= S_TX_WR;
                  csn_q   <= 1'b0;
                  we_q    <= 1'b1;
                  adrs_q  <= ADR_DATA;
                  data_q  <= fifo_rdata;
               end else if (go_rx) begin
                  state_q <= S_RX_RD;
                  csn_q   <= 1'b0;
                  oe_q    <= 1'b1;
                  adrs_q  <= ADR_DATA;
               end
            end
            S_RX_RD: begin
               state_q <= S_RWAIT;
               wait_q  <= WAIT_INIT;
            end
            S_RWAIT: begin
               if (wait_q != 3'd0) wait_q <= wait_q - 3'd1;
            end
            S_TX_WR: begin
               gap_q <= !gap_q;
               if (!gap_q) cnt_q <= cnt_q + 16'd1;
            end
            default: ;
         endcase

         // Transaction end (or IDLE with enable) overrides the per-state move above.
         if (start_poll) begin
            state_q <= S_POLL;
            csn_q   <= 1'b0;
            oe_q    <= 1'b1;
            adrs_q  <= ADR_STATUS;
            busy_q  <= 1'b1;
         end else if (txn_done) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
         end
      end
   end

   assign data_in    = data_q;
   assign adrs       = adrs_q;
   assign CSn        = csn_q;
   assign WE         = we_q;
   assign OE         = oe_q;
   assign busy       = busy_q;
   assign fifo_full  = fifo_full_w;
   assign byte_count = cnt_q;

endmodule

// File: doc/lb_echo_master.md
# lb_echo_master

Hardware local-bus initiator that drives the `lb_UART_toplevel` register interface with the same `CSn/WE/OE/adrs/data` signalling the PicoBlaze echo firmware uses. It is a drop-in replacement for the `echo` processor.

- Polls the UART status register.
- Pulls received bytes into a small FIFO, optionally case-folding them.
- Writes them back to the transmitter when it is ready.

It sits beside `lb_UART_toplevel` and `lb_reset` in the system top level. It gives a firmware-free echo path for bring-up and for cross-checking the soft processor.

## Interface
Parameters:
- `FIFO_DEPTH`, 4, echo buffer depth in bytes, power of two, ≥2.
- `READ_WAIT`, 1, wait cycles between a read strobe and read-data capture, 1..7.
- `CASE_FOLD`, 0, when 1 converts ASCII `a`–`z` (0x61–0x7A) to upper case on FIFO entry.

Ports:
- `clk` in 1: system clock; all state on the rising edge.
- `reset_ns` in 1: asynchronous, active-low reset.
- `enable` in 1: run request; level-sensitive.
- `data_out` in 8: read data returned by the UART (named from the UART side).
- `data_in` out 8: write data to the UART (TX byte).
- `adrs` out 1: register select; 0 = DATA, 1 = STATUS.
- `CSn` out 1: chip select, active low, one cycle per access.
- `WE` out 1: write strobe, active high, only with `CSn`=0.
- `OE` out 1: read strobe, active high, only with `CSn`=0.
- `busy` out 1: FSM not in IDLE.
- `fifo_full` out 1: FIFO holds `FIFO_DEPTH` bytes.
- `byte_count` out 16: bytes written to the transmitter.

## Operation
UART register map (fixed):
- STATUS bit0 = `rx_ready`.
- STATUS bit1 = `tx_ready`.
- Reading DATA clears `rx_ready`.
- Writing DATA starts transmission and clears `tx_ready`.

FSM states:
- **IDLE**: bus idle. Go to POLL when `enable`=1.
- **POLL**: one strobe, `CSn`=0, `OE`=1, `adrs`=1. Go to PWAIT.
- **PWAIT**: `READ_WAIT` cycles. Capture `data_out[1:0]` into the status register on the clock edge ending the last wait cycle. Go to DECIDE.
- **DECIDE**: one cycle, priority in this order:
  - `tx_ready` and FIFO not empty → TX_WR.
  - else `rx_ready` and FIFO not full → RX_RD.
  - else → POLL, or IDLE if `enable`=0.
- **RX_RD**: one strobe, `CSn`=0, `OE`=1, `adrs`=0. Go to RWAIT.
- **RWAIT**: `READ_WAIT` cycles. On the edge ending the last wait cycle, push `data_out` (folded if `CASE_FOLD`) into the FIFO. Go to POLL, or IDLE if `enable`=0.
- **TX_WR**: one strobe, `CSn`=0, `WE`=1, `adrs`=0, `data_in` = FIFO head. Pop the FIFO and increment `byte_count` on that edge. Go to POLL, or IDLE if `enable`=0.

Behaviour rules:
- Only one access per transaction; strobes are never back-to-back without an intervening non-strobe cycle.
- Full FIFO: the byte is not read and stays in the UART. Bytes are never dropped by this block.
- `enable` deasserted mid-transaction: the current transaction completes, then the FSM enters IDLE. FIFO contents are retained and resume on re-enable.
- `byte_count` wraps 0xFFFF → 0x0000.
- Bus idle values: `CSn`=1, `WE`=0, `OE`=0. `adrs` and `data_in` hold their last value.

## Timing
- Reset values:
  - state IDLE.
  - `CSn`=1, `WE`=0, `OE`=0, `adrs`=0, `data_in`=0x00.
  - `busy`=0, `fifo_full`=0, `byte_count`=0.
  - FIFO empty, status register 0.
- Reset assertion mid-access deasserts `CSn`/`WE`/`OE` immediately (asynchronous).
- All outputs are registered.
- With `READ_WAIT`=1, a poll costs 3 cycles (POLL, PWAIT, DECIDE).
- Echo latency with `READ_WAIT`=1, empty FIFO and `tx_ready`=1: the poll strobe seeing `rx_ready` is cycle 0; `OE` for DATA is at cycle 3; `WE` with the byte is at cycle 8.
- First POLL strobe occurs 1 cycle after `enable` is sampled high in IDLE.
- FIFO push and pop never coincide; only one transaction occurs per DECIDE.

## Structure
- `lb_echo_pkg` holds:
  - state enum.
  - `ADR_DATA`=0 and `ADR_STATUS`=1.
  - status bit indices `ST_RX_READY`=0 and `ST_TX_READY`=1.
  - case-fold constants.
- One sub-module, `lb_byte_fifo` (parameterised depth):
  - 8-bit synchronous FIFO.
  - push/pop, empty/full flags.
  - pointer width `$clog2(FIFO_DEPTH)+1`.
  - same clock and reset.

## Test plan
- Reset and idle: reset with `enable`=0, then release. Required: `CSn`=1, `WE`=0, `OE`=0, `busy`=0 for 20 cycles.
- Single echo: UART model returns 0x41 with `rx_ready`=1 and `tx_ready`=1. Required: a DATA read `OE` at cycle 3 and `WE` with `data_in`=0x41 at cycle 8; `byte_count`=1.
- Case fold: with `CASE_FOLD`=1, send 0x61, 0x7A, 0x5B, 0x30. Required: written bytes are 0x41, 0x5A, 0x5B, 0x30.
- Back-pressure: hold `tx_ready`=0 and supply 6 bytes. Required: exactly 4 DATA reads, then `fifo_full`=1 with no further DATA reads. Releasing `tx_ready` echoes all 6 bytes in order.
- Enable drop mid-RX_RD: required: RWAIT completes, the byte is pushed, the FSM goes to IDLE with the FIFO retained. Re-enable: the byte is echoed.
- Count wrap and async reset: preload via 65536 writes. Required: `byte_count`=0x0000. Assert `reset_ns` during a TX_WR strobe: `WE` drops in the same cycle.
